// File: rtl/layer_3_maxpool2x2.sv
// 2x2 stride-2 max-pool over a raster stream of NUM_CH packed FP32 channels per beat.
// Even input rows fold horizontal pair maxima into a row buffer; odd rows combine their
// pair maxima with the buffered value and emit one pooled pixel per 2x2 block.
// Optional feature macro: LAYER_3_MAXPOOL_FRAME_DONE_EN adds a frame_done output pulse
// coincident with the last pooled pixel of each frame.
module layer_3_maxpool2x2 #(
    parameter int unsigned DATA_WIDTH    = 32,
    parameter int unsigned NUM_CH        = 32,
    parameter int unsigned DATA_IN_WIDTH = 1024,
    parameter int unsigned IN_SIZE       = 208
) (
    input  logic                     Clk,
    input  logic                     Rst,
    input  logic [DATA_IN_WIDTH-1:0] data_in,
    input  logic                     valid_in,
    output logic [DATA_IN_WIDTH-1:0] data_out,
    output logic                     valid_out
`ifdef LAYER_3_MAXPOOL_FRAME_DONE_EN
    ,
    output logic                     frame_done
`endif
);

    localparam int unsigned OUT_SIZE = IN_SIZE / 2;
    localparam int unsigned CW       = (IN_SIZE > 1) ? $clog2(IN_SIZE) : 1;
    localparam int unsigned BW       = (OUT_SIZE > 1) ? $clog2(OUT_SIZE) : 1;

    typedef enum logic {StEven, StOdd} phase_t;

    phase_t                   phase_q;
    logic [CW-1:0]            col_q;
    logic [DATA_IN_WIDTH-1:0] pair_q;
    logic [DATA_IN_WIDTH-1:0] data_out_q;
    logic                     valid_out_q;
    logic [DATA_IN_WIDTH-1:0] rowbuf_q [OUT_SIZE];

    logic [BW-1:0]            buf_idx;
    logic [DATA_IN_WIDTH-1:0] buf_rd;
    logic [DATA_IN_WIDTH-1:0] h_max;
    logic [DATA_IN_WIDTH-1:0] pooled;
    logic                     col_last;

`ifdef LAYER_3_MAXPOOL_FRAME_DONE_EN
    logic [CW-1:0]            row_q;
    logic                     frame_done_q;
`endif

    // IEEE-754 max without NaN/Inf handling; sign-magnitude ordering, +0 beats -0.
    function automatic logic [DATA_WIDTH-1:0] fp_max(input logic [DATA_WIDTH-1:0] a,
                                                     input logic [DATA_WIDTH-1:0] b);
        if (a[DATA_WIDTH-1] != b[DATA_WIDTH-1]) begin
            return a[DATA_WIDTH-1] ? b : a;
        end else if (!a[DATA_WIDTH-1]) begin
            return (a[DATA_WIDTH-2:0] >= b[DATA_WIDTH-2:0]) ? a : b;
        end else begin
            return (a[DATA_WIDTH-2:0] <= b[DATA_WIDTH-2:0]) ? a : b;
        end
    endfunction

    assign buf_idx  = BW'(col_q >> 1);
    assign buf_rd   = rowbuf_q[buf_idx];
    assign col_last = (col_q == CW'(IN_SIZE - 1));

    // Per-channel horizontal pair max, then vertical max against the buffered even row.
    always_comb begin
        h_max  = '0;
        pooled = '0;
        for (int k = 0; k < int'(NUM_CH); k++) begin
            h_max[k*DATA_WIDTH +: DATA_WIDTH] =
                fp_max(pair_q[k*DATA_WIDTH +: DATA_WIDTH], data_in[k*DATA_WIDTH +: DATA_WIDTH]);
            pooled[k*DATA_WIDTH +: DATA_WIDTH] =
                fp_max(h_max[k*DATA_WIDTH +: DATA_WIDTH], buf_rd[k*DATA_WIDTH +: DATA_WIDTH]);
        end
    end

    // Row buffer: written with pair maxima on even rows; contents need no reset.
    always_ff @(posedge Clk) begin
        if (Rst && valid_in && col_q[0] && (phase_q == StEven)) begin
            rowbuf_q[buf_idx] <= h_max;
        end
    end

    // Position counters, row-parity FSM and registered outputs.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            phase_q     <= StEven;
            col_q       <= '0;
            pair_q      <= '0;
            data_out_q  <= '0;
            valid_out_q <= 1'b0;
`ifdef LAYER_3_MAXPOOL_FRAME_DONE_EN
            row_q        <= '0;
            frame_done_q <= 1'b0;
`endif
        end else begin
            valid_out_q <= 1'b0;
`ifdef LAYER_3_MAXPOOL_FRAME_DONE_EN
            frame_done_q <= 1'b0;
`endif
            if (valid_in) begin
                if (!col_q[0]) begin
                    pair_q <= data_in;
                end else if (phase_q == StOdd) begin
                    data_out_q  <= pooled;
                    valid_out_q <= 1'b1;
`ifdef LAYER_3_MAXPOOL_FRAME_DONE_EN
                    frame_done_q <= col_last && (row_q == CW'(IN_SIZE - 1));
`endif
                end
                if (col_last) begin
                    col_q   <= '0;
                    phase_q <= (phase_q == StEven) ? StOdd : StEven;
`ifdef LAYER_3_MAXPOOL_FRAME_DONE_EN
                    row_q <= (row_q == CW'(IN_SIZE - 1)) ? '0 : row_q + 1'b1;
`endif
                end else begin
                    col_q <= col_q + 1'b1;
                end
            end
        end
    end

    assign data_out  = data_out_q;
    assign valid_out = valid_out_q;
`ifdef LAYER_3_MAXPOOL_FRAME_DONE_EN
    assign frame_done = frame_done_q;
`endif

endmodule

// File: tb/tb_layer_3_maxpool2x2.sv
// Scoreboard bench for layer_3_maxpool2x2 on a reduced 8x8, 4-channel configuration.
module tb_layer_3_maxpool2x2;

    localparam int DW  = 32;
    localparam int NCH = 4;
    localparam int IW  = DW * NCH;
    localparam int SZ  = 8;
    localparam int OSZ = SZ / 2;

    logic          Clk = 1'b0;
    logic          Rst = 1'b1;
    logic [IW-1:0] data_in = '0;
    logic          valid_in = 1'b0;
    logic [IW-1:0] data_out;
    logic          valid_out;
`ifdef LAYER_3_MAXPOOL_FRAME_DONE_EN
    logic          frame_done;
    int            done_cnt = 0;
`endif

    layer_3_maxpool2x2 #(
        .DATA_WIDTH   (DW),
        .NUM_CH       (NCH),
        .DATA_IN_WIDTH(IW),
        .IN_SIZE      (SZ)
    ) dut (
        .Clk      (Clk),
        .Rst      (Rst),
        .data_in  (data_in),
        .valid_in (valid_in),
        .data_out (data_out),
        .valid_out(valid_out)
`ifdef LAYER_3_MAXPOOL_FRAME_DONE_EN
        ,
        .frame_done(frame_done)
`endif
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic [IW-1:0] data;
        int            due;
        logic          last;
    } exp_t;

    exp_t          q[$];
    exp_t          cur;
    logic [IW-1:0] got[$];
    logic [DW-1:0] img[SZ][SZ][NCH];
    logic [IW-1:0] last_exp = '0;
    logic          exp_v;
    int            vectors = 0;
    int            errors = 0;
    int            cyc = 0;

    // Ordering key: maps FP32 bit patterns onto an unsigned scale monotone in value.
    function automatic logic [31:0] key(input logic [31:0] x);
        return x[31] ? ~x : (x | 32'h8000_0000);
    endfunction

    function automatic logic [31:0] ref_max(input logic [31:0] a, input logic [31:0] b);
        return (key(a) >= key(b)) ? a : b;
    endfunction

    // Small integer to FP32 bit pattern.
    function automatic logic [31:0] itof(input int n);
        int m;
        int e;
        if (n == 0) return 32'h0;
        m = (n < 0) ? -n : n;
        e = 0;
        for (int i = 0; i < 31; i++) if ((m >> i) != 0) e = i;
        return {(n < 0), 8'(127 + e), 23'((m << (23 - e)) & 32'h7F_FFFF)};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Scoreboard checker, sampled 1 time unit after each rising edge.
    always @(posedge Clk) begin
        cyc = cyc + 1;
        #1;
        exp_v = (q.size() > 0) && (q[0].due == cyc);
        if (valid_out || exp_v) begin
            vectors++;
            assert (valid_out === exp_v) else begin
                errors++;
                $error("FAIL pulse_timing cyc=%0d observed=%b expected=%b", cyc, valid_out, exp_v);
            end
            if (exp_v) begin
                cur = q.pop_front();
                last_exp = cur.data;
                if (valid_out === 1'b1) begin
                    got.push_back(data_out);
                    vectors++;
                    assert (data_out === cur.data) else begin
                        errors++;
                        $error("FAIL pooled_data cyc=%0d observed=%h expected=%h",
                               cyc, data_out, cur.data);
                    end
`ifdef LAYER_3_MAXPOOL_FRAME_DONE_EN
                    if (frame_done === 1'b1) done_cnt++;
                    vectors++;
                    assert (frame_done === cur.last) else begin
                        errors++;
                        $error("FAIL frame_done cyc=%0d observed=%b expected=%b",
                               cyc, frame_done, cur.last);
                    end
`endif
                end
            end
        end else begin
            vectors++;
            assert (data_out === last_exp) else begin
                errors++;
                $error("FAIL data_hold cyc=%0d observed=%h expected=%h", cyc, data_out, last_exp);
            end
`ifdef LAYER_3_MAXPOOL_FRAME_DONE_EN
            vectors++;
            assert (frame_done === 1'b0) else begin
                errors++;
                $error("FAIL frame_done_idle cyc=%0d observed=%b expected=0", cyc, frame_done);
            end
`endif
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge Clk);
            valid_in = 1'b0;
        end
    endtask

    task automatic drive_beat(input int r, input int c);
        logic [IW-1:0] d;
        logic [IW-1:0] e;
        for (int k = 0; k < NCH; k++) d[k*DW +: DW] = img[r][c][k];
        @(negedge Clk);
        data_in  = d;
        valid_in = 1'b1;
        if ((r % 2 == 1) && (c % 2 == 1)) begin
            for (int k = 0; k < NCH; k++) begin
                e[k*DW +: DW] = ref_max(ref_max(img[r-1][c-1][k], img[r-1][c][k]),
                                        ref_max(img[r][c-1][k], img[r][c][k]));
            end
            q.push_back('{data: e, due: cyc + 1, last: (r == SZ - 1) && (c == SZ - 1)});
        end
    endtask

    // Sends a frame in raster order; stops before (stop_r, stop_c) when that lies inside it.
    task automatic send_frame(input bit gaps, input int stop_r, input int stop_c);
        for (int r = 0; r < SZ; r++) begin
            for (int c = 0; c < SZ; c++) begin
                if (r == stop_r && c == stop_c) return;
                if (gaps && $urandom_range(0, 1) == 1) idle(1 + $urandom_range(0, 2));
                drive_beat(r, c);
            end
        end
    endtask

    task automatic fill_index();
        for (int r = 0; r < SZ; r++)
            for (int c = 0; c < SZ; c++)
                for (int k = 0; k < NCH; k++) img[r][c][k] = itof(r * SZ + c);
    endtask

    // Random finite values (exponent < 255), with signed zeros sprinkled in.
    task automatic fill_random();
        for (int r = 0; r < SZ; r++)
            for (int c = 0; c < SZ; c++)
                for (int k = 0; k < NCH; k++) begin
                    img[r][c][k] = $urandom & 32'hBFFF_FFFF;
                    if ($urandom_range(0, 7) == 0) img[r][c][k] = {1'($urandom), 31'h0};
                end
    endtask

    task automatic finish_frame(input string tag, input int n_exp);
        idle(3);
        chk({tag, "_pulse_count"}, got.size(), n_exp);
        chk({tag, "_queue_drained"}, q.size(), 0);
    endtask

    initial begin
        #1 Rst = 1'b0;
        idle(3);
        chk("reset_valid_out", {31'h0, valid_out}, 0);
        chk("reset_data_out", data_out[31:0], 32'h0);
        @(negedge Clk) Rst = 1'b1;
        idle(2);

        // Index-valued frame: each output is the bottom-right pixel of its block.
        got.delete();
        fill_index();
        send_frame(1'b0, -1, -1);
        finish_frame("index", OSZ * OSZ);
        chk("index_first", got[0][31:0], itof(SZ + 1));
        chk("index_second", got[1][DW +: DW], itof(SZ + 3));
        chk("index_row1", got[OSZ][(NCH-1)*DW +: DW], itof(3 * SZ + 1));
        chk("index_last", got[OSZ*OSZ-1][31:0], itof(SZ * SZ - 1));

        // Random frame with directed sign cases and per-lane independence blocks.
        got.delete();
        fill_random();
        img[0][0][0] = 32'hBF80_0000; img[0][1][0] = 32'hC040_0000;
        img[1][0][0] = 32'hBF00_0000; img[1][1][0] = 32'hC000_0000;
        img[0][2][0] = 32'h8000_0000; img[0][3][0] = 32'h0000_0000;
        img[1][2][0] = 32'hBF80_0000; img[1][3][0] = 32'hC000_0000;
        img[2][0][0] = itof(50); img[2][1][0] = itof(1);
        img[3][0][0] = itof(2);  img[3][1][0] = itof(3);
        img[2][0][NCH-1] = itof(1); img[2][1][NCH-1] = itof(2);
        img[3][0][NCH-1] = itof(3); img[3][1][NCH-1] = itof(100);
        send_frame(1'b0, -1, -1);
        finish_frame("random", OSZ * OSZ);
        chk("neg_max", got[0][31:0], 32'hBF00_0000);
        chk("signed_zero", got[1][31:0], 32'h0000_0000);
        chk("lane0_topleft", got[OSZ][31:0], itof(50));
        chk("lane_last_botright", got[OSZ][(NCH-1)*DW +: DW], itof(100));

        // Same data delivered with random idle gaps.
        got.delete();
        send_frame(1'b1, -1, -1);
        finish_frame("gapped", OSZ * OSZ);
        chk("gapped_neg_max", got[0][31:0], 32'hBF00_0000);

        // Reset mid-frame, then a full fresh frame.
        fill_random();
        send_frame(1'b0, 5, 3);
        idle(2);
        @(negedge Clk);
        valid_in = 1'b0;
        Rst = 1'b0;
        q.delete();
        last_exp = '0;
        idle(3);
        chk("midreset_valid_out", {31'h0, valid_out}, 0);
        @(negedge Clk) Rst = 1'b1;
        got.delete();
        fill_random();
        send_frame(1'b0, -1, -1);
        finish_frame("post_reset", OSZ * OSZ);

        // Two back-to-back frames with no idle gap between them.
        got.delete();
`ifdef LAYER_3_MAXPOOL_FRAME_DONE_EN
        done_cnt = 0;
`endif
        fill_index();
        send_frame(1'b0, -1, -1);
        send_frame(1'b0, -1, -1);
        finish_frame("back_to_back", 2 * OSZ * OSZ);
        chk("b2b_frame2_first", got[OSZ*OSZ][31:0], itof(SZ + 1));
`ifdef LAYER_3_MAXPOOL_FRAME_DONE_EN
        chk("frame_done_count", done_cnt, 2);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete within the time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
